// File: rtl/reset_sequencer_if.sv
// Board-side inputs and channel-reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_LOCKS    = 2
);
  logic                    btn_i;
  logic [NUM_LOCKS-1:0]    locked_i;
  logic                    soft_reset_i;
  logic [NUM_CHANNELS-1:0] reset_o;
  logic                    all_released_o;
  logic [3:0]              cause_o;

  modport master (
    output btn_i, locked_i, soft_reset_i,
    input  reset_o, all_released_o, cause_o
  );

  modport slave (
    input  btn_i, locked_i, soft_reset_i,
    output reset_o, all_released_o, cause_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Board reset controller: conditions lock/button inputs, waits for PLL lock,
// then releases the channel resets in index order and records the last cause.
//
// state       | meaning
// S_ASSERT    | all channels in reset for one cycle
// S_WAIT_LOCK | waiting for all locks and a released button
// S_POR_COUNT | locks stable, counting POR_CYCLES before channel 0
// S_RELEASE   | staggered release of channels 1..N-1
// S_RUN       | every channel released
module reset_sequencer #(
  parameter int NUM_CHANNELS     = 4,
  parameter int NUM_LOCKS        = 2,
  parameter int POR_CYCLES       = 31,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int STAGE_GAP_CYCLES = 16,
  parameter bit BTN_ACTIVE_LOW   = 1'b1
) (
  input logic              clk,
  input logic              reset_i,
  reset_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int SW = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic BTN_REL_LEVEL = BTN_ACTIVE_LOW;

  typedef enum logic [2:0] {
    S_ASSERT, S_WAIT_LOCK, S_POR_COUNT, S_RELEASE, S_RUN
  } state_t;

  logic [NUM_LOCKS-1:0]    r_lock_s1, r_lock_s2;
  logic                    r_btn_s1, r_btn_s2;
  logic                    r_btn_deb;
  logic [DW-1:0]           r_db_cnt;
  logic                    r_press_evt;
  state_t                  r_state;
  logic [PW-1:0]           r_por_cnt;
  logic [SW-1:0]           r_stg_cnt;
  logic [CW-1:0]           r_chan;
  logic [NUM_CHANNELS-1:0] r_rst;
  logic                    r_all_rel;
  logic [3:0]              r_cause;

  logic w_btn_pressed, w_locks_ok, w_trig_lock, w_trig_soft, w_trig_btn, w_trig_any;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_lock_s1 <= '0;
      r_lock_s2 <= '0;
      r_btn_s1  <= BTN_REL_LEVEL;
      r_btn_s2  <= BTN_REL_LEVEL;
    end else begin
      r_lock_s1 <= bus.locked_i;
      r_lock_s2 <= r_lock_s1;
      r_btn_s1  <= bus.btn_i;
      r_btn_s2  <= r_btn_s1;
    end
  end

  // Debounced state is kept in "pressed" polarity regardless of pin polarity.
  assign w_btn_pressed = r_btn_s2 ^ BTN_REL_LEVEL;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_btn_deb   <= 1'b0;
      r_db_cnt    <= '0;
      r_press_evt <= 1'b0;
    end else begin
      r_press_evt <= 1'b0;
      if (w_btn_pressed == r_btn_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_deb   <= ~r_btn_deb;
        r_db_cnt    <= '0;
        r_press_evt <= ~r_btn_deb;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  assign w_locks_ok  = &r_lock_s2;
  assign w_trig_lock = ~w_locks_ok & ((r_state == S_RELEASE) | (r_state == S_RUN));
  assign w_trig_soft = bus.soft_reset_i;
  assign w_trig_btn  = r_press_evt;
  assign w_trig_any  = ((r_state == S_POR_COUNT) | (r_state == S_RELEASE) | (r_state == S_RUN))
                       & (w_trig_lock | w_trig_soft | w_trig_btn);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_ASSERT;
      r_rst     <= '1;
      r_all_rel <= 1'b0;
      r_cause   <= 4'b0001;
      r_por_cnt <= '0;
      r_stg_cnt <= '0;
      r_chan    <= '0;
    end else if (w_trig_any) begin
      r_state   <= S_ASSERT;
      r_rst     <= '1;
      r_all_rel <= 1'b0;
      r_cause   <= {w_trig_soft, w_trig_lock, w_trig_btn, 1'b0};
      r_por_cnt <= '0;
      r_stg_cnt <= '0;
      r_chan    <= '0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          r_state   <= S_WAIT_LOCK;
          r_rst     <= '1;
          r_por_cnt <= '0;
          r_stg_cnt <= '0;
          r_chan    <= '0;
        end
        S_WAIT_LOCK: begin
          if (w_locks_ok && !r_btn_deb) begin
            r_state   <= S_POR_COUNT;
            r_por_cnt <= '0;
          end
        end
        S_POR_COUNT: begin
          if (!w_locks_ok) begin
            r_state   <= S_WAIT_LOCK;
            r_por_cnt <= '0;
          end else if (r_por_cnt == PW'(POR_CYCLES)) begin
            r_rst[0]  <= 1'b0;
            r_stg_cnt <= '0;
            if (NUM_CHANNELS == 1) begin
              r_state   <= S_RUN;
              r_all_rel <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
              r_chan  <= CW'(1);
            end
          end else begin
            r_por_cnt <= r_por_cnt + PW'(1);
          end
        end
        S_RELEASE: begin
          if (r_stg_cnt == SW'(STAGE_GAP_CYCLES - 1)) begin
            r_stg_cnt     <= '0;
            r_rst[r_chan] <= 1'b0;
            if (r_chan == CW'(NUM_CHANNELS - 1)) begin
              r_state   <= S_RUN;
              r_all_rel <= 1'b1;
            end else begin
              r_chan <= r_chan + CW'(1);
            end
          end else begin
            r_stg_cnt <= r_stg_cnt + SW'(1);
          end
        end
        S_RUN: ;
        default: r_state <= S_ASSERT;
      endcase
    end
  end

  assign bus.reset_o        = r_rst;
  assign bus.all_released_o = r_all_rel;
  assign bus.cause_o        = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_CHANNELS=3, POR_CYCLES=8,
// DEBOUNCE_CYCLES=4, STAGE_GAP_CYCLES=2.
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  reset_sequencer_if #(.NUM_CHANNELS(3), .NUM_LOCKS(2)) bus ();

  reset_sequencer #(
    .NUM_CHANNELS(3), .NUM_LOCKS(2), .POR_CYCLES(8),
    .DEBOUNCE_CYCLES(4), .STAGE_GAP_CYCLES(2), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_i(reset_i), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.btn_i = 1'b1; bus.locked_i = 2'b11; bus.soft_reset_i = 1'b0;
    reset_i = 1'b1;
    tick(3);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL reset_rst: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.all_released_o !== 1'b0) begin n_err++; $display("FAIL reset_allrel: got %b expected 0", bus.all_released_o); end
    n_cmp++; if (bus.cause_o !== 4'b0001) begin n_err++; $display("FAIL reset_cause: got %b expected 0001", bus.cause_o); end
  endtask

  task automatic test_powerup;
    logic [2:0] exp;
    reset_i = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      tick(1);
      exp = {(e < 15), (e < 13), (e < 11)};
      n_cmp++; if (bus.reset_o !== exp) begin n_err++; $display("FAIL powerup_rst e%0d: got %b expected %b", e, bus.reset_o, exp); end
      n_cmp++; if (bus.all_released_o !== (e >= 15)) begin n_err++; $display("FAIL powerup_allrel e%0d: got %b expected %b", e, bus.all_released_o, (e >= 15)); end
    end
    n_cmp++; if (bus.cause_o !== 4'b0001) begin n_err++; $display("FAIL powerup_cause: got %b expected 0001", bus.cause_o); end
  endtask

  task automatic test_late_lock;
    reset_i = 1'b1; bus.locked_i = 2'b01;
    tick(2);
    reset_i = 1'b0;
    tick(20);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL late_wait: got %b expected 111", bus.reset_o); end
    bus.locked_i = 2'b11;
    tick(6);
    bus.locked_i = 2'b10;
    tick(1);
    bus.locked_i = 2'b11;
    tick(11);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL late_e10: got %b expected 111", bus.reset_o); end
    tick(1);
    n_cmp++; if (bus.reset_o !== 3'b110) begin n_err++; $display("FAIL late_e11: got %b expected 110", bus.reset_o); end
    tick(4);
    n_cmp++; if (bus.all_released_o !== 1'b1) begin n_err++; $display("FAIL late_run: got %b expected 1", bus.all_released_o); end
  endtask

  task automatic test_soft_reset;
    logic [2:0] exp;
    bus.soft_reset_i = 1'b1;
    tick(1);
    bus.soft_reset_i = 1'b0;
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL soft_rst: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b1000) begin n_err++; $display("FAIL soft_cause: got %b expected 1000", bus.cause_o); end
    n_cmp++; if (bus.all_released_o !== 1'b0) begin n_err++; $display("FAIL soft_allrel: got %b expected 0", bus.all_released_o); end
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      exp = {(e < 15), (e < 13), (e < 11)};
      n_cmp++; if (bus.reset_o !== exp) begin n_err++; $display("FAIL soft_release e%0d: got %b expected %b", e, bus.reset_o, exp); end
    end
  endtask

  task automatic test_button;
    for (int i = 0; i < 10; i++) begin
      bus.btn_i = 1'b0; tick(1);
      bus.btn_i = 1'b1; tick(1);
    end
    tick(4);
    n_cmp++; if (bus.reset_o !== 3'b000) begin n_err++; $display("FAIL bounce_rst: got %b expected 000", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b1000) begin n_err++; $display("FAIL bounce_cause: got %b expected 1000", bus.cause_o); end
    bus.btn_i = 1'b0;
    tick(6);
    n_cmp++; if (bus.reset_o !== 3'b000) begin n_err++; $display("FAIL press_e6: got %b expected 000", bus.reset_o); end
    tick(1);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL press_e7: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b0010) begin n_err++; $display("FAIL press_cause: got %b expected 0010", bus.cause_o); end
    tick(3);
    bus.btn_i = 1'b1;
    tick(15);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL btnrel_e15: got %b expected 111", bus.reset_o); end
    tick(1);
    n_cmp++; if (bus.reset_o !== 3'b110) begin n_err++; $display("FAIL btnrel_e16: got %b expected 110", bus.reset_o); end
    tick(4);
    n_cmp++; if (bus.all_released_o !== 1'b1) begin n_err++; $display("FAIL btnrel_run: got %b expected 1", bus.all_released_o); end
  endtask

  task automatic test_simultaneous;
    bus.soft_reset_i = 1'b1;
    tick(1);
    bus.soft_reset_i = 1'b0;
    tick(11);
    n_cmp++; if (bus.reset_o !== 3'b110) begin n_err++; $display("FAIL simul_e11: got %b expected 110", bus.reset_o); end
    bus.locked_i = 2'b10;
    tick(2);
    n_cmp++; if (bus.reset_o !== 3'b100) begin n_err++; $display("FAIL simul_e13: got %b expected 100", bus.reset_o); end
    bus.soft_reset_i = 1'b1;
    tick(1);
    bus.soft_reset_i = 1'b0;
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL simul_rst: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b1100) begin n_err++; $display("FAIL simul_cause: got %b expected 1100", bus.cause_o); end
    tick(10);
    bus.soft_reset_i = 1'b1;
    tick(1);
    bus.soft_reset_i = 1'b0;
    tick(2);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL waitlock_rst: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b1100) begin n_err++; $display("FAIL waitlock_cause: got %b expected 1100", bus.cause_o); end
    bus.locked_i = 2'b11;
    tick(11);
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL relock_e10: got %b expected 111", bus.reset_o); end
    tick(1);
    n_cmp++; if (bus.reset_o !== 3'b110) begin n_err++; $display("FAIL relock_e11: got %b expected 110", bus.reset_o); end
    tick(1);
  endtask

  task automatic test_async_reset;
    logic [2:0] exp;
    n_cmp++; if (bus.reset_o !== 3'b110) begin n_err++; $display("FAIL async_pre: got %b expected 110", bus.reset_o); end
    reset_i = 1'b1;
    #1;
    n_cmp++; if (bus.reset_o !== 3'b111) begin n_err++; $display("FAIL async_rst: got %b expected 111", bus.reset_o); end
    n_cmp++; if (bus.cause_o !== 4'b0001) begin n_err++; $display("FAIL async_cause: got %b expected 0001", bus.cause_o); end
    #2;
    reset_i = 1'b0;
    for (int e = 0; e <= 15; e++) begin
      tick(1);
      exp = {(e < 15), (e < 13), (e < 11)};
      n_cmp++; if (bus.reset_o !== exp) begin n_err++; $display("FAIL async_release e%0d: got %b expected %b", e, bus.reset_o, exp); end
    end
    n_cmp++; if (bus.all_released_o !== 1'b1) begin n_err++; $display("FAIL async_allrel: got %b expected 1", bus.all_released_o); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_late_lock();
    test_soft_reset();
    test_button();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
